bin_to_bcd_seq: RTL and testbench

//  Sequential shift-add-3 (double-dabble) binary-to-BCD converter.

---
 rtl/bin_to_bcd_seq.sv | 118 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-add-3 (double-dabble) binary-to-BCD converter.
// Accepts a WIDTH-bit value on a valid/ready handshake. It does one shift per cycle
// for WIDTH cycles, then registers the packed BCD result with a one-cycle bcd_valid strobe.
// Optional feature macro: LEADING_ZERO_BLANK_EN. When it is defined, digits above the
// most significant nonzero digit are replaced with the blank code 4'hF.
//
// state | meaning
// IDLE  | ready for a request, outputs held
// SHIFT | one add-3 / shift step per cycle, WIDTH steps in total
// DONE  | publish result, strobe bcd_valid, return to IDLE
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  bin_valid,
  output logic                  bin_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  ovf_4dig
);

  localparam int SW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [SW-1:0]   shift_reg;
  logic [CW-1:0]   cnt;

  logic [4*DIGITS-1:0] bcd_field;
  logic [4*DIGITS-1:0] bcd_final;
  logic                ovf_next;

  // All BCD nibbles are adjusted in parallel before the shift; no inter-nibble carries occur.
  function automatic logic [SW-1:0] add3_shift(input logic [SW-1:0] r);
    logic [SW-1:0] t;
    t = r;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[WIDTH + 4*i +: 4] >= 4'd5)
        t[WIDTH + 4*i +: 4] = t[WIDTH + 4*i +: 4] + 4'd3;
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  // Result formatting: overflow flag from raw digits, optional leading-zero blanking.
  always_comb begin
    bcd_field = shift_reg[SW-1 -: 4*DIGITS];
    bcd_final = bcd_field;
    ovf_next  = 1'b0;
    for (int i = 4; i < DIGITS; i++) begin
      if (bcd_field[4*i +: 4] != 4'd0)
        ovf_next = 1'b1;
    end
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int i = DIGITS-1; i >= 1; i--) begin
        if (bcd_field[4*i +: 4] != 4'd0)
          seen = 1'b1;
        if (!seen)
          bcd_final[4*i +: 4] = 4'hF;
      end
    end
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      bin_ready <= 1'b1;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      ovf_4dig  <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bin_valid) begin
            shift_reg <= {{(4*DIGITS){1'b0}}, bin_in};
            cnt       <= '0;
            bin_ready <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= add3_shift(shift_reg);
          cnt       <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= DONE;
        end
        DONE: begin
          bcd_out   <= bcd_final;
          ovf_4dig  <= ovf_next;
          bcd_valid <= 1'b1;
          bin_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          bin_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq using an arithmetic (div/mod) reference model.
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic                clock_100Mhz = 1'b0;
  logic                reset;
  logic [WIDTH-1:0]    bin_in;
  logic                bin_valid;
  logic                bin_ready;
  logic [4*DIGITS-1:0] bcd_out;
  logic                bcd_valid;
  logic                ovf_4dig;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .bin_in       (bin_in),
    .bin_valid    (bin_valid),
    .bin_ready    (bin_ready),
    .bcd_out      (bcd_out),
    .bcd_valid    (bcd_valid),
    .ovf_4dig     (ovf_4dig)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_100Mhz);
    #1;
  endtask

  // Reference: decimal digits by division, optional blanking above the top nonzero digit.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned d[DIGITS];
    int unsigned p;
    int top;
    p   = 1;
    top = 0;
    r   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = (v / p) % 10;
      p    = p * 10;
      if (d[i] != 0) top = i;
    end
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = d[i][3:0];
`ifdef LEADING_ZERO_BLANK_EN
      if (i > top) r[4*i +: 4] = 4'hF;
`endif
    end
    return r;
  endfunction

  task automatic run_conv(input logic [WIDTH-1:0] v, input bit scramble);
    int lat;
    bit seen;
    logic [4*DIGITS-1:0] exp_bcd;
    exp_bcd = ref_bcd(v);
    bin_in    = v;
    bin_valid = 1'b1;
    check_eq("ready_idle", bin_ready, 1);
    tick();
    bin_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (scramble) begin
        bin_in    = WIDTH'($urandom);
        bin_valid = $urandom_range(0, 1);
      end
      tick();
      lat++;
      if (bcd_valid) seen = 1'b1;
      else check_eq("ready_busy", bin_ready, 0);
    end
    bin_valid = 1'b0;
    check_eq("latency", lat, 17);
    check_eq("bcd_out", bcd_out, exp_bcd);
    check_eq("ovf_4dig", ovf_4dig, (v > 9999) ? 1 : 0);
    tick();
    check_eq("valid_one_cycle", bcd_valid, 0);
    check_eq("bcd_held", bcd_out, exp_bcd);
  endtask

  initial begin
    logic [WIDTH-1:0] dirs[$];
    logic [WIDTH-1:0] acc_q[$];
    logic [WIDTH-1:0] v;
    int pulses;

    reset     = 1'b1;
    bin_in    = '0;
    bin_valid = 1'b0;
    tick();
    tick();
    check_eq("rst_bcd_out", bcd_out, 0);
    check_eq("rst_bcd_valid", bcd_valid, 0);
    check_eq("rst_ovf", ovf_4dig, 0);
    check_eq("rst_ready", bin_ready, 1);
    reset = 1'b0;
    tick();

    // Directed boundaries and examples.
    dirs = '{16'd1234, 16'd65535, 16'd9999, 16'd10000, 16'd0, 16'd7, 16'd10, 16'd100, 16'd99};
    foreach (dirs[i]) run_conv(dirs[i], 1'b0);

    // Random values, with bin_in/bin_valid disturbed mid-conversion.
    for (int i = 0; i < 20; i++) run_conv(WIDTH'($urandom), 1'b1);

    // Continuous bin_valid with bin_in changing every cycle.
    for (int k = 0; k < 4*18; k++) begin
      bin_in    = WIDTH'($urandom);
      bin_valid = 1'b1;
      check_eq("stream_ready", bin_ready, (k % 18 == 0) ? 1 : 0);
      if (k % 18 == 0) acc_q.push_back(bin_in);
      tick();
      if (k % 18 == 17) begin
        v = acc_q.pop_front();
        check_eq("stream_valid", bcd_valid, 1);
        check_eq("stream_bcd", bcd_out, ref_bcd(v));
        check_eq("stream_ovf", ovf_4dig, (v > 9999) ? 1 : 0);
      end else begin
        check_eq("stream_novalid", bcd_valid, 0);
      end
    end
    bin_valid = 1'b0;
    tick();

    // Reset mid-conversion.
    run_conv(16'd4321, 1'b0);
    bin_in    = 16'd55555;
    bin_valid = 1'b1;
    tick();
    bin_valid = 1'b0;
    repeat (8) tick();
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_bcd", bcd_out, 0);
    check_eq("midrst_ovf", ovf_4dig, 0);
    check_eq("midrst_valid", bcd_valid, 0);
    check_eq("midrst_ready", bin_ready, 1);
    tick();
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      tick();
      if (bcd_valid) pulses++;
    end
    check_eq("midrst_no_pulse", pulses, 0);
    check_eq("midrst_ready_after", bin_ready, 1);
    check_eq("midrst_bcd_held", bcd_out, 0);
    run_conv(16'd8765, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
